// File: rtl/mac_sequencer.sv
// -----------------------------------------------------------------------------
// mac_sequencer
//   Dot-product engine for a TAPS-long kernel. It loads a set of signed weights
//   once and then computes one dot product per window of TAPS activations.
//   A single signed multiplier is reused for every tap; the accumulator result
//   is held on y_data until the downstream side takes it.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset
//   w_valid  in   weight offered
//   w_data   in   signed weight, WIDTH_B bits
//   w_ready  out  weight accepted when w_valid is also high
//   a_valid  in   activation offered
//   a_data   in   signed activation, WIDTH_A bits
//   a_ready  out  activation accepted when a_valid is also high
//   y_valid  out  dot-product result available
//   y_data   out  signed result, ACC_WIDTH bits
//   y_ready  in   downstream accepts the result when y_valid is also high
//   reload   in   sampled only on the result handshake; requests new weights
//   loaded   out  a complete weight set is held
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// mac_mult
//   Signed full-width multiplier shared by the sequencer.
//
// Ports
//   a  in   signed operand, WA bits
//   b  in   signed operand, WB bits
//   p  out  signed product, WA+WB bits
// -----------------------------------------------------------------------------
module mac_mult #(
  parameter int WA = 9,
  parameter int WB = 5
) (
  input  logic signed [WA-1:0]    a,
  input  logic signed [WB-1:0]    b,
  output logic signed [WA+WB-1:0] p
);

  // Both operands are signed, so they are sign-extended to the product width.
  assign p = a * b;

endmodule

// -----------------------------------------------------------------------------
// state    | meaning
// ---------+-------------------------------------------------------------------
// LOAD_W   | accepting weights into weight[idx]; w_ready high
// COMPUTE  | accepting activations, one multiply-accumulate each; a_ready high
// OUTPUT   | result held on y_data until y handshake; y_valid high
// -----------------------------------------------------------------------------
module mac_sequencer #(
  parameter int WIDTH_A   = 9,
  parameter int WIDTH_B   = 5,
  parameter int TAPS      = 9,
  parameter int ACC_WIDTH = WIDTH_A + WIDTH_B + 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        w_valid,
  input  logic signed [WIDTH_B-1:0]   w_data,
  output logic                        w_ready,
  input  logic                        a_valid,
  input  logic signed [WIDTH_A-1:0]   a_data,
  output logic                        a_ready,
  output logic                        y_valid,
  output logic signed [ACC_WIDTH-1:0] y_data,
  input  logic                        y_ready,
  input  logic                        reload,
  output logic                        loaded
);

  localparam int IDX_W  = $clog2(TAPS);
  localparam int PROD_W = WIDTH_A + WIDTH_B;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  typedef enum logic [1:0] {
    LOAD_W  = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]          idx_q;
  logic signed [WIDTH_B-1:0] weight_q [TAPS];
  logic signed [ACC_WIDTH-1:0] acc_q;

  logic w_hs, a_hs, y_hs;
  logic idx_last;

  logic signed [WIDTH_B-1:0]   w_sel;
  logic signed [PROD_W-1:0]    product;
  logic signed [ACC_WIDTH-1:0] product_ext;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_W;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Ready/valid outputs decode registered state only, so no input-to-output
  // combinational path exists. Handshakes are formed from those decodes.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    w_ready = 1'b0;
    a_ready = 1'b0;
    y_valid = 1'b0;
    loaded  = 1'b0;

    case (state_q)
      LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid && idx_last) begin
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        a_ready = 1'b1;
        loaded  = 1'b1;
        if (a_valid && idx_last) begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        y_valid = 1'b1;
        loaded  = 1'b1;
        if (y_ready) begin
          state_d = reload ? LOAD_W : COMPUTE;
        end
      end
      default: begin
        state_d = LOAD_W;
      end
    endcase
  end

  assign w_hs     = w_ready && w_valid;
  assign a_hs     = a_ready && a_valid;
  assign y_hs     = y_valid && y_ready;
  assign idx_last = (idx_q == LAST_IDX);

  // ---------------------------------------------------------------------------
  // Shared multiplier: the weight for the current tap is selected by idx.
  // ---------------------------------------------------------------------------
  assign w_sel = weight_q[idx_q];

  mac_mult #(
    .WA (WIDTH_A),
    .WB (WIDTH_B)
  ) u_mult (
    .a (a_data),
    .b (w_sel),
    .p (product)
  );

  // Signed size cast sign-extends the product to the accumulator width.
  assign product_ext = ACC_WIDTH'(product);

  // ---------------------------------------------------------------------------
  // Tap index, shared by weight loading and accumulation. It wraps to zero on
  // the last tap of either phase, so it is already zero entering the next one.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else if (w_hs || a_hs) begin
      idx_q <= idx_last ? '0 : idx_q + IDX_W'(1);
    end else if (y_hs) begin
      idx_q <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Weight store. A reload overwrites entries in order; entries not yet
  // rewritten keep their previous value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        weight_q[i] <= '0;
      end
    end else if (w_hs) begin
      weight_q[idx_q] <= w_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator. Tap 0 overwrites instead of adding, so no explicit clear is
  // needed between windows. Sum wraps in two's complement. acc is not touched
  // in OUTPUT, which keeps y_data stable under backpressure.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (a_hs) begin
      acc_q <= (idx_q == '0) ? product_ext : acc_q + product_ext;
    end
  end

  assign y_data = acc_q;

endmodule
